// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared cache memory types and arbiter state enum
// Purpose: request/response structs shared by both caches, the arbiter and the
//          memory controller, plus the arbiter FSM state encoding.
// Ports:   none (package)
package cache_mem_arbiter_pkg;

   typedef struct packed {
      logic [31:0]  addr;
      logic [127:0] data;
      logic         rw;     // 1 = write
      logic         valid;
   } mem_req_type;

   typedef struct packed {
      logic [127:0] data;
      logic         ready;
   } mem_data_type;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GRANT_IC = 2'd1,
      ST_GRANT_DC = 2'd2
   } arb_state_e;

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
// rtl/cache_mem_arbiter_rr_arbiter2.sv - two-way round-robin pick and grant register
// Purpose: picks a winner among up to two requesters, favouring the one not
//          granted last, and holds the one-hot grant.
// Ports:   clk_i, rst_i     - clock, synchronous active-high reset
//          i_req[1:0]       - candidate requesters (bit0 icache, bit1 dcache)
//          i_update         - load o_pick into the grant and last-granted registers
//          i_clear          - drop the grant to 00
//          o_pick[1:0]      - combinational one-hot winner (00 if no candidate)
//          o_grant[1:0]     - registered one-hot grant
module rr_arbiter2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] i_req,
   input  logic       i_update,
   input  logic       i_clear,
   output logic [1:0] o_pick,
   output logic [1:0] o_grant
);

   logic       r_last_dc;   // 0: icache granted last (reset value), 1: dcache
   logic [1:0] r_grant;

   always_comb begin
      o_pick = 2'b00;
      case (i_req)
         2'b01:   o_pick = 2'b01;
         2'b10:   o_pick = 2'b10;
         2'b11:   o_pick = r_last_dc ? 2'b01 : 2'b10;
         default: o_pick = 2'b00;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_last_dc <= 1'b0;
         r_grant   <= 2'b00;
      end else if (i_update) begin
         r_last_dc <= o_pick[1];
         r_grant   <= o_pick;
      end else if (i_clear) begin
         r_grant   <= 2'b00;
      end
   end

   assign o_grant = r_grant;

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - icache/dcache arbiter for a shared memory controller
// Purpose: grants the memory port to one cache at a time, forwards the owner's
//          request and the memory response, aborts stuck grants via a watchdog
//          and counts grants per requester.
// Ports:   clk_i, rst_i           - clock, synchronous active-high reset
//          ic_req_i / ic_res_o    - icache request in / response out
//          dc_req_i / dc_res_o    - dcache request in / response out
//          mem_req_o / mem_res_i  - shared memory request out / response in
//          grant_o[1:0]           - one-hot owner (bit0 icache, bit1 dcache)
//          timeout_o              - sticky watchdog abort flag
//          ic_grants_o/dc_grants_o- saturating grant counts
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  mem_req_type      ic_req_i,
   output mem_data_type     ic_res_o,
   input  mem_req_type      dc_req_i,
   output mem_data_type     dc_res_o,
   output mem_req_type      mem_req_o,
   input  mem_data_type     mem_res_i,
   output logic [1:0]       grant_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] ic_grants_o,
   output logic [CNT_W-1:0] dc_grants_o
);

   localparam int              WD_W   = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

   arb_state_e       r_state;
   logic [WD_W-1:0]  r_wdog;
   logic [CNT_W-1:0] r_ic_cnt;
   logic [CNT_W-1:0] r_dc_cnt;
   logic             r_timeout;

   logic [1:0]       w_arb_req;
   logic [1:0]       w_pick;
   logic             w_owner_valid;
   logic             w_timeout_hit;
   logic             w_enter;
   logic             w_to_idle;

   // While an owner holds valid nobody else is a candidate; on release only
   // the other requester is, so a hand-over never passes through IDLE.
   always_comb begin
      w_arb_req     = 2'b00;
      w_owner_valid = 1'b0;
      case (r_state)
         ST_IDLE: w_arb_req = {dc_req_i.valid, ic_req_i.valid};
         ST_GRANT_IC: begin
            w_owner_valid = ic_req_i.valid;
            if (!ic_req_i.valid) w_arb_req = {dc_req_i.valid, 1'b0};
         end
         ST_GRANT_DC: begin
            w_owner_valid = dc_req_i.valid;
            if (!dc_req_i.valid) w_arb_req = {1'b0, ic_req_i.valid};
         end
         default: w_arb_req = 2'b00;
      endcase
   end

   // Watchdog abort takes precedence over any hand-over in the same cycle.
   assign w_timeout_hit = (r_state != ST_IDLE) && !mem_res_i.ready && (r_wdog == WD_MAX);
   assign w_enter       = !w_timeout_hit && (w_pick != 2'b00);
   assign w_to_idle     = w_timeout_hit ||
                          ((r_state != ST_IDLE) && !w_owner_valid && (w_pick == 2'b00));

   rr_arbiter2 u_rr (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_req    (w_arb_req),
      .i_update (w_enter),
      .i_clear  (w_to_idle),
      .o_pick   (w_pick),
      .o_grant  (grant_o)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_wdog    <= '0;
         r_ic_cnt  <= '0;
         r_dc_cnt  <= '0;
         r_timeout <= 1'b0;
      end else if (w_timeout_hit) begin
         r_state   <= ST_IDLE;
         r_wdog    <= '0;
         r_timeout <= 1'b1;
      end else if (w_enter) begin
         r_state <= w_pick[1] ? ST_GRANT_DC : ST_GRANT_IC;
         r_wdog  <= '0;
         if (w_pick[1]) begin
            if (r_dc_cnt != {CNT_W{1'b1}}) r_dc_cnt <= r_dc_cnt + CNT_W'(1);
         end else begin
            if (r_ic_cnt != {CNT_W{1'b1}}) r_ic_cnt <= r_ic_cnt + CNT_W'(1);
         end
      end else if (w_to_idle) begin
         r_state <= ST_IDLE;
         r_wdog  <= '0;
      end else if (r_state != ST_IDLE) begin
         r_wdog <= mem_res_i.ready ? '0 : r_wdog + WD_W'(1);
      end
   end

   // Response ready seen in IDLE falls through here untouched and is dropped.
   always_comb begin
      mem_req_o = '0;
      ic_res_o  = '0;
      dc_res_o  = '0;
      case (r_state)
         ST_GRANT_IC: begin
            mem_req_o = ic_req_i;
            ic_res_o  = mem_res_i;
         end
         ST_GRANT_DC: begin
            mem_req_o = dc_req_i;
            dc_res_o  = mem_res_i;
         end
         default: mem_req_o = '0;
      endcase
   end

   assign timeout_o   = r_timeout;
   assign ic_grants_o = r_ic_cnt;
   assign dc_grants_o = r_dc_cnt;

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum number of cycles a grant may wait for a memory ready before being aborted.
REQ-002 SHALL have parameter CNT_W, default 32: width of the per-requester grant counters.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port ic_req_i, input, mem_req_type: instruction-cache memory request (addr, 128-bit data, rw, valid).
REQ-006 SHALL have port ic_res_o, output, mem_data_type: instruction-cache response (128-bit data, ready).
REQ-007 SHALL have port dc_req_i, input, mem_req_type: data-cache memory request.
REQ-008 SHALL have port dc_res_o, output, mem_data_type: data-cache response.
REQ-009 SHALL have port mem_req_o, output, mem_req_type: request to the shared memory controller.
REQ-010 SHALL have port mem_res_i, input, mem_data_type: response from the shared memory controller.
REQ-011 SHALL have port grant_o, output, 2: one-hot current owner, bit0 = icache, bit1 = dcache; 00 when idle.
REQ-012 SHALL have port timeout_o, output, 1: sticky flag set when a grant is aborted by the watchdog.
REQ-013 SHALL have ports ic_grants_o and dc_grants_o, output, CNT_W each: saturating counts of grants issued.

Function
REQ-014 SHALL implement the states IDLE, GRANT_IC and GRANT_DC.
REQ-015 In IDLE, mem_req_o SHALL have valid=0 and all other fields 0, and both *_res_o.ready SHALL be 0.
REQ-016 In IDLE with exactly one valid requester, the FSM SHALL enter that requester's GRANT state on the next edge (1-cycle arbitration latency).
REQ-017 In IDLE with both requesters valid, the FSM SHALL grant the requester not granted last (round-robin); after reset the last-granted requester is icache, so dcache wins the first tie.
REQ-018 In a GRANT state, mem_req_o SHALL equal the owner's request combinationally.
REQ-019 In a GRANT state, the owner's *_res_o SHALL equal mem_res_i combinationally, and the non-owner SHALL see data=0, ready=0.
REQ-020 The grant SHALL be held while the owner's valid is 1, including across a write-back followed by an allocate.
REQ-021 When the owner's valid is 0 at an edge, the FSM SHALL switch directly to the other requester's GRANT state if that requester is valid (no idle bubble), otherwise it SHALL return to IDLE.
REQ-022 In a GRANT state, mem_req_o.valid SHALL equal the owner's valid, so it is 0 in the release cycle.
REQ-023 The last-granted register and the winner's grant counter SHALL update on every edge that enters a GRANT state.
REQ-024 Grant counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 A watchdog counter SHALL clear on entering a GRANT state and on every cycle with mem_res_i.ready=1, and SHALL increment otherwise while in a GRANT state.
REQ-026 When the watchdog reaches TIMEOUT_CYCLES-1 without a ready, the FSM SHALL go to IDLE and set timeout_o, which stays 1 until reset; the aborted requester re-arbitrates normally.
REQ-027 mem_res_i.ready arriving while in IDLE SHALL be ignored and not forwarded.
REQ-028 Simultaneous owner release and new requests SHALL resolve per REQ-021, never granting both; grant_o is always one-hot or 00.

Reset
REQ-029 rst_i SHALL force, on the next edge: state IDLE, last-granted icache, watchdog 0, both grant counters 0, timeout_o 0.
REQ-030 Reset asserted mid-grant SHALL drop mem_req_o.valid from the next cycle and SHALL NOT complete the transaction.

Structure
REQ-031 mem_req_type, mem_data_type and the arbiter state enum SHALL live in the shared cache package.
REQ-032 TIMEOUT_CYCLES SHALL remain a module parameter.
REQ-033 The round-robin pick and the grant register SHALL form one sub-module, rr_arbiter2; the FSM, watchdog and counters SHALL stay in cache_mem_arbiter.

Verification
REQ-034 Lone icache read (addr 0x0000_0100, ready after 3 cycles) -> grant_o=01 one cycle after valid; ic_res_o.ready=1 in the ready cycle; ic_grants_o=1; dc_res_o.ready=0 throughout.
REQ-035 Both valid from reset -> dcache granted first; on dcache release icache granted the next cycle with no IDLE cycle; counters each 1.
REQ-036 Dcache write-back (rw=1, addr 0x0000_2000) then allocate (rw=0) with valid held -> single grant spanning both; mem_req_o.rw goes 1 then 0; icache request meanwhile stays stalled.
REQ-037 Memory never returns ready, TIMEOUT_CYCLES=16 -> state returns to IDLE 16 cycles after grant and timeout_o=1, staying 1 after further traffic until rst_i.
REQ-038 rst_i pulsed mid-grant -> next cycle grant_o=00, mem_req_o.valid=0, counters 0; CNT_W=4 with 20 icache grants -> ic_grants_o holds at 15.
